// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO: data width, write-side FSM states
// and Gray/binary pointer conversions.
package fifo_pkg;

    localparam int DATA_W    = 32;
    localparam int PTR_MAX_W = 16;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } wr_state_t;

    // Pointers narrower than PTR_MAX_W are zero-extended on the way in and
    // truncated on the way out; both conversions are width-independent that way.
    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b = g;
        for (int i = 1; i < PTR_MAX_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_sched_if.sv
// Requester handshake plus memory write port of the FIFO write-side scheduler.
interface fifo_wr_sched_if
    import fifo_pkg::*;
#(
    parameter int depth = 7,
    parameter int NREQ  = 4
);

    logic [NREQ-1:0]        req;
    logic [DATA_W*NREQ-1:0] req_data;
    logic [NREQ-1:0]        grant;
    logic                   wen;
    logic [depth-1:0]       waddr;
    logic [DATA_W-1:0]      wdata;

    modport master (
        input  req, req_data,
        output grant, wen, waddr, wdata
    );

    modport slave (
        output req, req_data,
        input  grant, wen, waddr, wdata
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first active request at or above prio, wrapping.
module rr_arbiter #(
    parameter int NREQ   = 4,
    parameter int PRIO_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]   req,
    input  logic              en,
    input  logic [PRIO_W-1:0] prio,
    output logic [NREQ-1:0]   grant,
    output logic [PRIO_W-1:0] prio_next
);

    int   idx;
    logic found;

    always_comb begin
        grant     = '0;
        prio_next = prio;
        found     = 1'b0;
        idx       = 0;
        if (en) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (int'(prio) + k) % NREQ;
                if (!found && req[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    prio_next  = PRIO_W'((idx + 1) % NREQ);
                end
            end
        end
    end

endmodule

// File: rtl/fifo_wr_sched.sv
// Write-side scheduler: arbitrates requesters onto the FIFO write port, owns the
// write pointer and derives full/almost-full/level; sequences flush.
module fifo_wr_sched
    import fifo_pkg::*;
#(
    parameter int depth     = 7,
    parameter int NREQ      = 4,
    parameter int AF_MARGIN = 4
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [depth:0]       r2wsync_ff2,
    fifo_wr_sched_if.master      bus,
    output logic [depth:0]       wptr,
    output logic                 wfull,
    output logic                 walmost_full,
    output logic [depth:0]       wlevel,
    output logic                 flush_done
);

    localparam int PW     = depth + 1;
    localparam int PRIO_W = $clog2(NREQ);
    localparam logic [depth:0] AF_LEVEL = PW'((1 << depth) - AF_MARGIN);

    wr_state_t         state;
    logic [PRIO_W-1:0] prio;
    logic [PRIO_W-1:0] prio_next;
    logic [depth:0]    wbin;
    logic [depth:0]    wgray;
    logic [depth:0]    rbin;
    logic [depth:0]    used;
    logic [NREQ-1:0]   grant;
    logic              arb_en;
    logic              any_grant;
    logic [DATA_W-1:0] sel_data;

    assign wgray = PW'(bin2gray(PTR_MAX_W'(wbin)));
    assign rbin  = PW'(gray2bin(PTR_MAX_W'(r2wsync_ff2)));
    assign used  = wbin - rbin;

    // Full is compared against the live write count, so a grant in the previous
    // cycle is already accounted for and back-to-back grants cannot overflow.
    assign wfull = (wgray == {~r2wsync_ff2[depth:depth-1], r2wsync_ff2[depth-2:0]});

    assign arb_en = reset && (state == RUN) && !wfull;

    rr_arbiter #(.NREQ(NREQ), .PRIO_W(PRIO_W)) u_arb (
        .req       (bus.req),
        .en        (arb_en),
        .prio      (prio),
        .grant     (grant),
        .prio_next (prio_next)
    );

    assign bus.grant = grant;
    assign any_grant = |grant;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_data = bus.req_data[DATA_W*i +: DATA_W];
            end
        end
    end

    // wptr trails wbin by one edge so the reader never sees a word before it is
    // in memory; flush exits only once the pipeline and the reader are both empty.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state        <= RUN;
            prio         <= '0;
            wbin         <= '0;
            wptr         <= '0;
            bus.wen      <= 1'b0;
            bus.waddr    <= '0;
            bus.wdata    <= '0;
            wlevel       <= '0;
            walmost_full <= 1'b0;
            flush_done   <= 1'b0;
        end else begin
            bus.wen <= any_grant;
            if (any_grant) begin
                bus.waddr <= wbin[depth-1:0];
                bus.wdata <= sel_data;
                wbin      <= wbin + PW'(1);
                prio      <= prio_next;
            end
            wptr         <= wgray;
            wlevel       <= used;
            walmost_full <= (used >= AF_LEVEL);
            flush_done   <= 1'b0;
            case (state)
                RUN: begin
                    if (flush) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (!bus.wen && (wptr == wgray) && (r2wsync_ff2 == wptr)) begin
                        state      <= RUN;
                        flush_done <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_sched.sv
// Randomised bench for fifo_wr_sched against a count-based model of the write side
// (depth=3, NREQ=4, AF_MARGIN=2).
module tb_fifo_wr_sched;

    localparam int DEPTH = 3;
    localparam int NREQ  = 4;
    localparam int AFM   = 2;
    localparam int CAP   = 8;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b0;
    logic        flush  = 1'b0;
    logic [3:0]  rq     = '0;
    logic [3:0]  wptr;
    logic [3:0]  wlevel;
    logic        wfull;
    logic        walmost_full;
    logic        flush_done;
    logic [31:0] data [NREQ];

    int errors = 0;
    int checks = 0;

    // Model: plain word counts for written, published and read words.
    int          m_wr, m_pub, m_rd, m_prio;
    bit          m_flush, m_inflight;
    logic        e_wen, e_af, e_fdone;
    logic [2:0]  e_waddr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wptr, e_level;

    fifo_wr_sched_if #(.depth(DEPTH), .NREQ(NREQ)) bif ();

    assign bif.req_data = {data[3], data[2], data[1], data[0]};

    fifo_wr_sched #(.depth(DEPTH), .NREQ(NREQ), .AF_MARGIN(AFM)) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .flush        (flush),
        .r2wsync_ff2  (rq),
        .bus          (bif.master),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .flush_done   (flush_done)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [3:0] gray(input int v);
        logic [3:0] b;
        b = 4'(v);
        return b ^ (b >> 1);
    endfunction

    function automatic int winner();
        if (!reset || m_flush || (m_wr - m_rd) == CAP) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (bif.req[(m_prio + k) % NREQ]) return (m_prio + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int g);
        if (g < 0) return 4'b0000;
        return 4'(1 << g);
    endfunction

    task automatic set_rd(input int v);
        m_rd = v;
        rq   = gray(v);
    endtask

    task automatic model_clear();
        m_wr = 0; m_pub = 0; m_prio = 0; m_flush = 0; m_inflight = 0;
        e_wen = 0; e_af = 0; e_fdone = 0; e_waddr = '0; e_wdata = '0;
        e_wptr = '0; e_level = '0;
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        int          g, wr_old;
        logic [31:0] d;
        bit          exit_now;
        g = winner();
        wr_old = m_wr;
        d = '0;
        if (g >= 0) d = data[g];
        @(posedge clk_in);
        if (!reset) begin
            model_clear();
        end else begin
            exit_now = m_flush && !m_inflight && (m_pub == m_wr) && (m_rd == m_wr);
            e_wptr  = gray(wr_old);
            e_level = 4'(wr_old - m_rd);
            e_af    = (wr_old - m_rd) >= (CAP - AFM);
            m_pub   = wr_old;
            e_wen   = (g >= 0);
            m_inflight = (g >= 0);
            if (g >= 0) begin
                e_waddr = 3'(wr_old);
                e_wdata = d;
                m_wr++;
                m_prio = (g + 1) % NREQ;
            end
            e_fdone = 0;
            if (!m_flush) begin
                if (flush) m_flush = 1;
            end else if (exit_now) begin
                m_flush = 0;
                e_fdone = 1;
            end
        end
        @(negedge clk_in);
        if (g >= 0) data[g] = $urandom();
    endtask

    task automatic do_reset();
        bif.req = '0;
        flush   = 1'b0;
        reset   = 1'b0;
        set_rd(0);
        model_clear();
        @(negedge clk_in);
        @(negedge clk_in);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        bif.req = 4'hF;
        #1;
        checks++; if (bif.grant !== 4'b0001) begin errors++; $display("[TB] FAIL reset_first_grant: got %b expected 0001", bif.grant); end
        repeat (3) tick();
        reset = 1'b0;
        model_clear();
        #1;
        checks++; if (bif.grant !== 4'b0000) begin errors++; $display("[TB] FAIL reset_grant: got %b expected 0000", bif.grant); end
        tick();
        checks++; if (bif.wen !== 1'b0) begin errors++; $display("[TB] FAIL reset_wen: got %b expected 0", bif.wen); end
        checks++; if (wptr !== 4'h0 || wlevel !== 4'h0) begin errors++; $display("[TB] FAIL reset_ptrs: got wptr=%h wlevel=%h expected 0 0", wptr, wlevel); end
        checks++; if (bif.waddr !== 3'h0 || bif.wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_wport: got waddr=%h wdata=%h expected 0 0", bif.waddr, bif.wdata); end
        checks++; if ({wfull, walmost_full, flush_done} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {wfull, walmost_full, flush_done}); end
        reset = 1'b1;
        #1;
        checks++; if (bif.grant !== 4'b0001) begin errors++; $display("[TB] FAIL reset_regrant: got %b expected 0001", bif.grant); end
    endtask

    task automatic test_fill();
        int order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int n = 0;
        do_reset();
        bif.req = 4'hF;
        for (int cyc = 0; cyc < 12; cyc++) begin
            #1;
            checks++; if (bif.grant !== onehot(winner())) begin errors++; $display("[TB] FAIL fill_grant: got %b expected %b", bif.grant, onehot(winner())); end
            if (bif.grant !== 4'b0000) begin
                checks++;
                if (n >= 8) begin errors++; $display("[TB] FAIL fill_extra_grant: got %b expected 0000", bif.grant); end
                else if (bif.grant !== onehot(order[n])) begin errors++; $display("[TB] FAIL fill_order: got %b expected %b", bif.grant, onehot(order[n])); end
                n++;
            end
            tick();
            checks++; if (bif.wen !== e_wen || bif.waddr !== e_waddr || bif.wdata !== e_wdata) begin errors++; $display("[TB] FAIL fill_wport: got %b/%h/%h expected %b/%h/%h", bif.wen, bif.waddr, bif.wdata, e_wen, e_waddr, e_wdata); end
            checks++; if (wlevel !== e_level || walmost_full !== e_af) begin errors++; $display("[TB] FAIL fill_level: got %h/%b expected %h/%b", wlevel, walmost_full, e_level, e_af); end
            checks++; if (wfull !== ((m_wr - m_rd) == CAP)) begin errors++; $display("[TB] FAIL fill_full: got %b expected %b", wfull, (m_wr - m_rd) == CAP); end
        end
        checks++; if (n !== 8) begin errors++; $display("[TB] FAIL fill_count: got %0d expected 8", n); end
        checks++; if (wfull !== 1'b1 || wlevel !== 4'd8 || walmost_full !== 1'b1) begin errors++; $display("[TB] FAIL fill_final: got full=%b level=%0d af=%b expected 1 8 1", wfull, wlevel, walmost_full); end
    endtask

    task automatic test_rotation();
        logic [3:0] prev = 4'b0000;
        bif.req = 4'b1010;
        for (int cyc = 0; cyc < 12; cyc++) begin
            set_rd(m_pub);
            #1;
            checks++; if (bif.grant !== onehot(winner())) begin errors++; $display("[TB] FAIL rot_grant: got %b expected %b", bif.grant, onehot(winner())); end
            if (bif.grant !== 4'b0000) begin
                checks++;
                if (bif.grant !== ((prev == 4'b0010) ? 4'b1000 : 4'b0010)) begin errors++; $display("[TB] FAIL rot_alternate: got %b after %b", bif.grant, prev); end
                prev = bif.grant;
            end
            tick();
            checks++; if (bif.wen !== e_wen || bif.wdata !== e_wdata) begin errors++; $display("[TB] FAIL rot_wdata: got %b/%h expected %b/%h", bif.wen, bif.wdata, e_wen, e_wdata); end
            checks++; if (wlevel !== e_level || wfull !== ((m_wr - m_rd) == CAP)) begin errors++; $display("[TB] FAIL rot_level: got %h/%b expected %h", wlevel, wfull, e_level); end
        end
    endtask

    task automatic test_wrap();
        int         start = m_wr;
        int         cyc = 0;
        bit         wrapped = 0;
        logic [3:0] prev_ptr = wptr;
        logic [2:0] prev_addr = bif.waddr;
        while (m_wr < start + 20 && cyc < 200) begin
            bif.req = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 1) == 1) set_rd(m_pub);
            #1;
            checks++; if (bif.grant !== onehot(winner())) begin errors++; $display("[TB] FAIL wrap_grant: got %b expected %b", bif.grant, onehot(winner())); end
            tick();
            checks++; if (bif.waddr !== e_waddr || wptr !== e_wptr) begin errors++; $display("[TB] FAIL wrap_ptr: got %h/%h expected %h/%h", bif.waddr, wptr, e_waddr, e_wptr); end
            checks++; if ($countones(prev_ptr ^ wptr) > 1) begin errors++; $display("[TB] FAIL wrap_gray_step: got %h after %h expected one bit change", wptr, prev_ptr); end
            checks++; if (wfull !== ((m_wr - m_rd) == CAP)) begin errors++; $display("[TB] FAIL wrap_full: got %b expected %b", wfull, (m_wr - m_rd) == CAP); end
            if (bif.wen === 1'b1) begin
                if (prev_addr == 3'd7 && bif.waddr == 3'd0) wrapped = 1;
                prev_addr = bif.waddr;
            end
            prev_ptr = wptr;
            cyc++;
        end
        checks++; if (m_wr < start + 20) begin errors++; $display("[TB] FAIL wrap_budget: got %0d words expected 20", m_wr - start); end
        checks++; if (wrapped !== 1'b1) begin errors++; $display("[TB] FAIL wrap_seen: got %b expected 1", wrapped); end
    endtask

    task automatic test_flush();
        int pulses = 0;
        bit resumed = 0;
        do_reset();
        bif.req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (bif.grant !== onehot(i % NREQ)) begin errors++; $display("[TB] FAIL flush_prefill: got %b expected %b", bif.grant, onehot(i % NREQ)); end
            tick();
        end
        bif.req = 4'h0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bif.req = 4'hF;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if (bif.grant !== 4'b0000) begin errors++; $display("[TB] FAIL flush_block: got %b expected 0000", bif.grant); end
            tick();
            checks++; if (flush_done !== 1'b0) begin errors++; $display("[TB] FAIL flush_early_done: got %b expected 0", flush_done); end
        end
        set_rd(5);
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if (bif.grant !== onehot(winner())) begin errors++; $display("[TB] FAIL flush_grant: got %b expected %b", bif.grant, onehot(winner())); end
            if (bif.grant !== 4'b0000) resumed = 1;
            tick();
            checks++; if (flush_done !== e_fdone) begin errors++; $display("[TB] FAIL flush_done_cycle: got %b expected %b", flush_done, e_fdone); end
            if (flush_done === 1'b1) pulses++;
        end
        checks++; if (pulses !== 1) begin errors++; $display("[TB] FAIL flush_pulses: got %0d expected 1", pulses); end
        checks++; if (resumed !== 1'b1) begin errors++; $display("[TB] FAIL flush_resume: got %b expected 1", resumed); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] d2;
        int          pulses = 0;
        bif.req = 4'h0;
        for (int i = 0; i < 4; i++) begin
            set_rd(m_pub);
            tick();
        end
        data[2] = $urandom();
        d2 = data[2];
        bif.req = 4'b0100;
        flush = 1'b1;
        #1;
        checks++; if (bif.grant !== 4'b0100) begin errors++; $display("[TB] FAIL sim_grant: got %b expected 0100", bif.grant); end
        tick();
        flush = 1'b0;
        bif.req = 4'hF;
        set_rd(m_wr - 1);
        checks++; if (bif.wen !== 1'b1 || bif.wdata !== d2) begin errors++; $display("[TB] FAIL sim_write: got %b/%h expected 1/%h", bif.wen, bif.wdata, d2); end
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bif.grant !== 4'b0000) begin errors++; $display("[TB] FAIL sim_block: got %b expected 0000", bif.grant); end
            tick();
            checks++; if (flush_done !== 1'b0) begin errors++; $display("[TB] FAIL sim_early_done: got %b expected 0", flush_done); end
        end
        set_rd(m_wr);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bif.grant !== onehot(winner())) begin errors++; $display("[TB] FAIL sim_resume_grant: got %b expected %b", bif.grant, onehot(winner())); end
            tick();
            checks++; if (flush_done !== e_fdone) begin errors++; $display("[TB] FAIL sim_done_cycle: got %b expected %b", flush_done, e_fdone); end
            if (flush_done === 1'b1) pulses++;
        end
        checks++; if (pulses !== 1) begin errors++; $display("[TB] FAIL sim_pulses: got %0d expected 1", pulses); end
    endtask

    initial begin
        bif.req = '0;
        for (int i = 0; i < NREQ; i++) data[i] = $urandom();
        model_clear();
        set_rd(0);
        @(negedge clk_in);
        $display("[TB] starting fifo_wr_sched bench");
        test_reset();
        test_fill();
        test_rotation();
        test_wrap();
        test_flush();
        test_simultaneous();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/fifo_wr_sched.md
# fifo_wr_sched

Write-side scheduler for the asynchronous FIFO. It shares the single FIFO write port among `NREQ` requesters using round-robin arbitration. It owns the write pointer in binary and Gray form, and derives full, almost-full and level from the read pointer already synchronised into the write domain. It also sequences a flush: new writes are blocked until the reader has drained every entry.

## Interface
Parameters:
- `depth`, 7: address bits. FIFO holds 2^depth entries; pointers are depth+1 bits.
- `NREQ`, 4: number of requesters, range 2..8.
- `AF_MARGIN`, 4: walmost_full asserts when wlevel >= 2^depth - AF_MARGIN.

Ports:
- `clk_in`  in  1: write-domain clock.
- `reset`  in  1: asynchronous, active-low.
- `flush`  in  1: synchronous flush request, write domain.
- `req`  in  NREQ: per-requester write request, level.
- `req_data`  in  32*NREQ: requester i data in bits [32i+31:32i].
- `r2wsync_ff2`  in  depth+1: Gray read pointer, already double-synchronised.
- `grant`  out  NREQ: one-hot, combinational, at most one bit set.
- `wen`  out  1: memory write enable, registered.
- `waddr`  out  depth: memory write address, registered.
- `wdata`  out  32: memory write data, registered.
- `wptr`  out  depth+1: Gray write pointer sent to the read-side synchroniser, registered.
- `wfull`  out  1: FIFO full.
- `walmost_full`  out  1: registered.
- `wlevel`  out  depth+1: occupancy as seen from the write side, registered.
- `flush_done`  out  1: one-cycle pulse.

## Operation
- Internal `wbin` is a (depth+1)-bit binary write count. `rbin` = gray-to-binary of `r2wsync_ff2`.
- Full condition: `wfull` = (bin2gray(wbin) == {~rq[depth:depth-1], rq[depth-2:0]}), with rq = `r2wsync_ff2`.
  - Combinational from registers only, so back-to-back grants never overflow.
- Level: `wlevel` <= (wbin - rbin) mod 2^(depth+1), registered every cycle. `walmost_full` is registered from the same values.
- Requester handshake:
  - Requester i holds `req[i]` and its data stable until it sees `grant[i]`.
  - `grant[i]` is high for exactly one cycle per accepted word.
  - The requester may drop `req[i]` or present new data on the cycle after the grant.
- Arbitration:
  - Eligible when state == RUN and `wfull` == 0.
  - Round-robin priority pointer `prio`, reset value 0. The winner is the first i with `req[i]`=1, scanning from `prio` upward and wrapping.
  - After a grant to i, `prio` <= (i+1) mod NREQ. With no grant, `prio` holds.
- State machine:
  - RUN: arbitration enabled. `flush`=1 at an edge -> FLUSH. A grant in the same cycle as `flush` is still honoured.
  - FLUSH: `grant`=0. Exit to RUN when `wen`=0, `wptr`==bin2gray(wbin) and `r2wsync_ff2`==`wptr`. `flush_done` pulses on the cycle after the exit edge.
  - `flush` asserted while in FLUSH is ignored.
- Reset values: state RUN; `prio`, `wbin`, `wptr`, `waddr`, `wdata`, `wlevel` = 0; `wen`, `walmost_full`, `flush_done` = 0.
  - `wfull` evaluates to 0 from the reset registers. `grant` = 0 while `reset`=0.
  - Reset asserted mid-flush or mid-write abandons the operation; no partial write is issued.
- Wrap-around: `wbin` wraps modulo 2^(depth+1); `waddr` = wbin[depth-1:0]. There is no special case at the wrap.

## Timing
- Cycle t: `grant[i]`=1 (combinational).
- Edge ending t:
  - `wen`<=1, `waddr`<=wbin[depth-1:0], `wdata`<=`req_data[i]`.
  - `wbin`<=wbin+1. `wfull` therefore reflects the new count in cycle t+1.
- Edge ending t+1: memory is written. `wptr`<=bin2gray(wbin).
  - The Gray pointer never advances before its data is in memory.
- Throughput: one word per cycle while requests are present and `wfull`=0.
- `wen` drops the cycle after the last grant.
- Flush latency: at least 2 cycles after `flush` (pipeline empty), plus read-side drain time, plus 2 synchroniser cycles.

## Structure
- Shared package `fifo_pkg`:
  - DATA_W = 32.
  - Functions bin2gray and gray2bin, parameterised on width.
  - State encoding RUN=1'b0, FLUSH=1'b1.
- Sub-module `rr_arbiter`, parameter NREQ. Inputs: `req`, `en`, `prio`. Outputs: one-hot `grant` and the next `prio`.
- All pointer, level and FSM logic lives in `fifo_wr_sched`.

## Test plan
All scenarios use depth=3 (8 entries), NREQ=4, AF_MARGIN=2.
- Reset: `reset`=0 mid-stream with `req`=4'hF -> all outputs 0 next cycle; after release, the first grant goes to requester 0.
- Fill: `req`=4'hF held, rq=0 -> grants in order 0,1,2,3,0,1,2,3; `waddr` 0..7; `wfull`=1 after 8 grants; no 9th grant; `wlevel`=8; `walmost_full`=1 from level 6.
- Rotation: `req`=4'b1010 continuous, rq tracking to keep not-full -> grants alternate 1,3,1,3; `wdata` matches the granted requester's data.
- Wrap: advance rq in steps while writing 20 words -> `waddr` wraps 7->0; `wptr` Gray sequence stays single-bit-change; never full while level < 8.
- Flush: 5 words written, `flush`=1 with `req`=4'hF -> no grants; drive rq=bin2gray(5) -> `flush_done` pulses once, then grants resume.
- Simultaneous: `flush` and `req[2]` in the same cycle -> that one grant is honoured and its word written; FLUSH then waits for rq=`wptr` including that word.
